// File: rtl/multicycle_control_unit_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared encodings for the multicycle MIPS controller: FSM state codes,
// opcode/funct constants, ALU_Control codes, datapath mux selects and the
// ALU_Op codes passed from the FSM to the ALU decoder.
// No ports (package).
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_GPIO_WB   = 4'd12
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU_Control codes
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // ALU_Op codes (FSM -> alu_decoder)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Mem_to_Reg selects
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_DATA   = 2'b01;
    localparam logic [1:0] M2R_GPIO   = 2'b10;

    // ALU_Src_B selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC_Src selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic funct_is_valid(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
// Controller <-> datapath bundle: instruction fields and Zero flow from the
// datapath into the controller, every datapath control strobe/select flows
// back out.
//   master : controller side (drives controls, samples Op/Funct/Zero)
//   slave  : datapath side
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PC_En;
    logic       I_or_D;
    logic       Mem_Write;
    logic       IR_Write;
    logic       Reg_Dst;
    logic [1:0] Mem_to_Reg;
    logic       Reg_Write;
    logic       ALU_Src_A;
    logic [1:0] ALU_Src_B;
    logic [2:0] ALU_Control;
    logic [1:0] PC_Src;

    modport master (
        input  Op, Funct, Zero,
        output PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
               Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src
    );

    modport slave (
        output Op, Funct, Zero,
        input  PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
               Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Maps the FSM's ALU_Op plus the instruction funct field to ALU_Control.
//   alu_op      in  2  00 ADD, 01 SUB, 10 decode from funct
//   funct       in  6  Instr[5:0]
//   alu_control out 3  ALU operation code
//   funct_valid out 1  funct is one of the supported R-type operations
// funct_valid ignores alu_op so DECODE can classify R-type legality while
// the ALU is busy computing the branch target.
// ----------------------------------------------------------------------------
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    always_comb begin
        alu_control = ALUC_ADD;
        funct_valid = funct_is_valid(funct);
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    default: alu_control = ALUC_AND;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
// Moore controller for the 32-bit multicycle MIPS datapath. One instruction
// in flight; FETCH/DECODE then an opcode-specific execute/writeback path.
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   ctrl         if   master side of multicycle_control_unit_if
//   state_o      out  current FSM state (debug)
//   illegal_op_o out  sticky flag: unsupported Op/Funct was decoded
//
// state       | meaning
// 0 FETCH     | IR <- Mem[PC], PC <- PC+4
// 1 DECODE    | branch target -> ALU_Out, dispatch on Op
// 2 MEM_ADR   | A + SignImm address for lw/sw
// 3 MEM_READ  | read data memory at ALU_Out
// 4 MEM_WB    | rt <- Data
// 5 MEM_WRITE | Mem[ALU_Out] <- B
// 6 EXECUTE   | R-type A op B
// 7 ALU_WB    | rd <- ALU_Out
// 8 BRANCH    | A - B compare, PC <- ALU_Out if taken
// 9 ADDI_EXEC | A + SignImm
// 10 ADDI_WB  | rt <- ALU_Out
// 11 JUMP     | PC <- jump target
// 12 GPIO_WB  | rt <- {24'b0, GPIO_i}
// ----------------------------------------------------------------------------
module multicycle_control_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter int         STATE_WIDTH = 4,
    parameter logic [5:0] GPIO_IN_OP  = 6'h3F
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   ctrl,
    output logic [STATE_WIDTH-1:0]      state_o,
    output logic                        illegal_op_o
);

    state_t     state_q;
    state_t     state_d;
    logic       set_illegal;

    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_use;

    logic [2:0] dec_alu_control;
    logic       funct_valid;
    logic       is_bne;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (ctrl.Funct),
        .alu_control (dec_alu_control),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            illegal_op_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) begin
                illegal_op_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        i_or_d      = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = M2R_ALUOUT;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_op      = ALUOP_ADD;
        alu_use     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_use   = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_use   = 1'b1;
                // GPIO_IN_OP is a parameter, so test it first in case it is
                // ever overridden onto a standard opcode.
                if (ctrl.Op == GPIO_IN_OP) begin
                    state_d = S_GPIO_WB;
                end else if (ctrl.Op == OP_LW || ctrl.Op == OP_SW) begin
                    state_d = S_MEM_ADR;
                end else if (ctrl.Op == OP_RTYPE && funct_valid) begin
                    state_d = S_EXECUTE;
                end else if (ctrl.Op == OP_BEQ || ctrl.Op == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (ctrl.Op == OP_ADDI) begin
                    state_d = S_ADDI_EXEC;
                end else if (ctrl.Op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d     = S_FETCH;
                    set_illegal = 1'b1;
                end
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_use   = 1'b1;
                state_d   = (ctrl.Op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                i_or_d  = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = M2R_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                alu_use   = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                alu_use   = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_use   = 1'b1;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_GPIO_WB: begin
                mem_to_reg = M2R_GPIO;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Encodings 13-15: recover to FETCH with all controls idle.
                state_d = S_FETCH;
            end
        endcase
    end

    assign is_bne = (ctrl.Op == OP_BNE);

    // Controls are held at zero for as long as reset is low, even though
    // state is already FETCH, so nothing strobes into the datapath.
    assign ctrl.PC_En       = reset & (pc_write | (branch & (ctrl.Zero ^ is_bne)));
    assign ctrl.I_or_D      = reset & i_or_d;
    assign ctrl.Mem_Write   = reset & mem_write;
    assign ctrl.IR_Write    = reset & ir_write;
    assign ctrl.Reg_Dst     = reset & reg_dst;
    assign ctrl.Mem_to_Reg  = reset ? mem_to_reg : 2'b00;
    assign ctrl.Reg_Write   = reset & reg_write;
    assign ctrl.ALU_Src_A   = reset & alu_src_a;
    assign ctrl.ALU_Src_B   = reset ? alu_src_b : 2'b00;
    assign ctrl.ALU_Control = (reset && alu_use) ? dec_alu_control : 3'b000;
    assign ctrl.PC_Src      = reset ? pc_src : 2'b00;

    assign state_o = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench for multicycle_control_unit: walks each instruction class
// through its state sequence and checks state_o, the full control word and
// the sticky illegal flag against hand-computed values.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] state_o;
    logic       illegal_op_o;
    int         vec = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .STATE_WIDTH (4),
        .GPIO_IN_OP  (6'h3F)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl         (bus.master),
        .state_o      (state_o),
        .illegal_op_o (illegal_op_o)
    );

    // {PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
    //  ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src}
    logic [15:0] ctrl_obs;
    assign ctrl_obs = {bus.PC_En, bus.I_or_D, bus.Mem_Write, bus.IR_Write,
                       bus.Reg_Dst, bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A,
                       bus.ALU_Src_B, bus.ALU_Control, bus.PC_Src};

    function automatic logic [15:0] cv(
        input logic pe, input logic iord, input logic mw, input logic irw,
        input logic rd, input logic [1:0] m2r, input logic rw, input logic sa,
        input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] ps);
        return {pe, iord, mw, irw, rd, m2r, rw, sa, sb, ac, ps};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] c);
        chk({tag, "/state"}, {12'h000, state_o}, {12'h000, st});
        chk({tag, "/ctrl"}, ctrl_obs, c);
    endtask

    task automatic ill(input string tag, input logic exp);
        chk({tag, "/illegal"}, {15'h0000, illegal_op_o}, {15'h0000, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] e_fetch, e_decode, e_madr, e_mread, e_mwb, e_mwrite;
    logic [15:0] e_aluwb, e_addiex, e_addiwb, e_jump, e_gpio, e_zero;

    initial begin
        e_zero   = 16'h0000;
        e_fetch  = cv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00);
        e_decode = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00);
        e_madr   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00);
        e_mread  = cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
        e_mwb    = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
        e_mwrite = cv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
        e_aluwb  = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
        e_addiex = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00);
        e_addiwb = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
        e_jump   = cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10);
        e_gpio   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);

        bus.Op    = 6'h00;
        bus.Funct = 6'h22;
        bus.Zero  = 1'b0;

        // Held in reset: everything zero
        @(negedge clk);
        step("reset", 4'd0, e_zero);
        ill("reset", 1'b0);

        // R-type SUB: 0,1,6,7,0
        reset = 1'b1;
        #1 step("sub_fetch", 4'd0, e_fetch);
        tick; step("sub_decode", 4'd1, e_decode);
        tick; step("sub_exec", 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b00));
        tick; step("sub_wb", 4'd7, e_aluwb);
        tick; step("sub_done", 4'd0, e_fetch);

        // R-type SLT, reset asserted while in EXECUTE
        bus.Funct = 6'h2A;
        tick; step("slt_decode", 4'd1, e_decode);
        tick; step("slt_exec", 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00));
        reset = 1'b0;
        #1 step("mid_reset", 4'd0, e_zero);
        tick; step("mid_reset_hold", 4'd0, e_zero);
        reset = 1'b1;
        #1 step("release_fetch", 4'd0, e_fetch);

        // lw: 0,1,2,3,4,0
        bus.Op = 6'h23;
        tick; step("lw_decode", 4'd1, e_decode);
        tick; step("lw_madr", 4'd2, e_madr);
        tick; step("lw_mread", 4'd3, e_mread);
        tick; step("lw_mwb", 4'd4, e_mwb);
        tick; step("lw_done", 4'd0, e_fetch);

        // sw: 0,1,2,5,0
        bus.Op = 6'h2B;
        tick; step("sw_decode", 4'd1, e_decode);
        tick; step("sw_madr", 4'd2, e_madr);
        tick; step("sw_mwrite", 4'd5, e_mwrite);
        tick; step("sw_done", 4'd0, e_fetch);

        // beq taken / not taken, bne taken / not taken
        bus.Op = 6'h04; bus.Zero = 1'b1;
        tick; step("beq1_decode", 4'd1, e_decode);
        tick; step("beq1_branch", 4'd8, cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01));
        tick; step("beq1_done", 4'd0, e_fetch);
        bus.Zero = 1'b0;
        tick; step("beq0_decode", 4'd1, e_decode);
        tick; step("beq0_branch", 4'd8, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01));
        tick; step("beq0_done", 4'd0, e_fetch);
        bus.Op = 6'h05; bus.Zero = 1'b0;
        tick; step("bne0_decode", 4'd1, e_decode);
        tick; step("bne0_branch", 4'd8, cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01));
        tick; step("bne0_done", 4'd0, e_fetch);
        bus.Zero = 1'b1;
        tick; step("bne1_decode", 4'd1, e_decode);
        tick; step("bne1_branch", 4'd8, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01));
        tick; step("bne1_done", 4'd0, e_fetch);

        // addi: 0,1,9,10,0
        bus.Op = 6'h08;
        tick; step("addi_decode", 4'd1, e_decode);
        tick; step("addi_exec", 4'd9, e_addiex);
        tick; step("addi_wb", 4'd10, e_addiwb);
        tick; step("addi_done", 4'd0, e_fetch);

        // j: 0,1,11,0
        bus.Op = 6'h02;
        tick; step("j_decode", 4'd1, e_decode);
        tick; step("j_jump", 4'd11, e_jump);
        tick; step("j_done", 4'd0, e_fetch);

        // GPIO_IN: 0,1,12,0
        bus.Op = 6'h3F;
        tick; step("gpio_decode", 4'd1, e_decode);
        tick; step("gpio_wb", 4'd12, e_gpio);
        tick; step("gpio_done", 4'd0, e_fetch);
        ill("legal_only", 1'b0);

        // Illegal opcode: 0,1,0 with flag set and held
        bus.Op = 6'h10;
        tick; step("badop_decode", 4'd1, e_decode);
        ill("badop_decode", 1'b0);
        tick; step("badop_done", 4'd0, e_fetch);
        ill("badop_set", 1'b1);
        bus.Op = 6'h02;
        tick; step("after_bad_decode", 4'd1, e_decode);
        tick; step("after_bad_jump", 4'd11, e_jump);
        ill("badop_sticky", 1'b1);

        // Only reset clears the flag
        reset = 1'b0;
        #1 ill("badop_cleared", 1'b0);
        step("reset2", 4'd0, e_zero);
        tick;
        reset = 1'b1;

        // R-type with unsupported funct (jr): illegal
        bus.Op = 6'h00; bus.Funct = 6'h08;
        #1 step("badfn_fetch", 4'd0, e_fetch);
        tick; step("badfn_decode", 4'd1, e_decode);
        tick; step("badfn_done", 4'd0, e_fetch);
        ill("badfn_set", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
